mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 selection datapath among eight requesters and feeds a single registered output channel. It computes the 3-bit select (binary encoding, requester i → sel = i) and the per-requester acknowledge. It captures the selected word into a one-entry output register with valid/ready backpressure. Optional per-requester lock supports bounded bursts. The block sits between multiple producers, such as writeback sources or bus masters, and one shared consumer.

Parameters:
WIDTH, 32, data width per requester and output
MAX_BURST, 4, maximum consecutive locked transfers by one owner (≥1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  8  request, bit i = requester i
lock  input  8  bit i: requester i asks to keep grant after its current transfer
in_data  input  8*WIDTH  requester i word at [i*WIDTH +: WIDTH]
ack  output  8  one-hot transfer strobe; bit i high = word i taken this edge
sel  output  3  select index of current winner
out_valid  output  1  out_data holds a valid word
out_data  output  WIDTH  registered selected word
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async, immediate) clears state:
  - out_valid=0, out_data=0
  - ptr=0 (highest priority = requester 0), last_sel=0
  - lock_active=0, owner=0, burst_cnt=0
  - ack=0 and sel=0 while reset is high.
- accept = !out_valid || out_ready.
- Winner (combinational):
  - If lock_active && req[owner], winner = owner.
  - Otherwise, winner = first i with req[i]=1, scanning ptr, ptr+1, … ptr+7 (mod 8).
  - any_req = |req.
- sel = winner when any_req, else last_sel.
- ack = onehot(winner) when accept && any_req, else 0. At most one ack bit is ever set.
- On an edge with ack≠0:
  - out_data <= in_data[winner]
  - out_valid <= 1
  - last_sel <= winner
  - ptr <= winner+1 mod 8 (7 wraps to 0)
  - new_cnt = (lock_active && winner==owner) ? burst_cnt+1 : 1
  - owner <= winner, burst_cnt <= new_cnt
  - lock_active <= lock[winner] && (new_cnt < MAX_BURST)
- On an edge with accept && !any_req:
  - out_valid <= 0
  - lock_active <= 0
  - out_data holds its value.
- If accept && lock_active && !req[owner], the lock is released. Arbitration is normal round-robin that same cycle.
- Stall (out_valid && !out_ready):
  - ack=0
  - out_data, out_valid, ptr, lock state and burst_cnt all frozen.
- Latency: 1 cycle from ack edge to out_valid/out_data. Throughput is 1 word/cycle while out_ready=1.
- Requester rules: a requester holds in_data stable while req is high and not acked. Dropping req before ack is legal and withdraws the request.
- MAX_BURST=1: lock has no effect.
- Reset asserted mid-operation discards the held word. The first grant after release follows priority from requester 0.

Test Plan:
- Reset, req=8'hFF, lock=0, out_ready=1, in_data[i]=i+0x100:
  - ack rotates 1,2,4,…,0x80,1.
  - out_data is 0x100,0x101,… one cycle later.
  - out_valid stays high.
- req=8'b0010_0100 held, out_ready=1 after reset: grants alternate 2,5,2,5; sel matches the winner.
- Backpressure: steady req=8'hFF, drop out_ready for 3 cycles while out_valid=1:
  - ack=0 and out_data unchanged for those cycles.
  - On resume, the next grant is the requester after the last acked one.
- Lock burst, MAX_BURST=4, req=8'hFF, lock=8'h08 held, ptr at 3: grant sequence 3,3,3,3,4,5,6.
- Lock release: owner 3 locked, req[3] drops after 2 transfers → next grant 4 with no idle cycle; after 4, lock state shows lock_active=0.
- Async reset pulse between clock edges mid-burst:
  - out_valid=0, out_data=0, ack=0 immediately.
  - After release with req=8'h81, first grant is 0, then 7.

Source files
------------

// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of the request-side and output-side signals of the 8-way
// round-robin arbiter.
//   req       : 8 request lines, bit i = requester i
//   lock      : 8 burst-hold requests, bit i = requester i
//   in_data   : 8 packed words, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-hot transfer strobe back to the requesters
//   sel       : index of the current winner
//   out_valid : out_data holds a word
//   out_data  : registered selected word
//   out_ready : consumer takes out_data this cycle
// Modport "slave" is the arbiter's view. Modport "master" is the
// environment's view (producers plus consumer).
interface mux8_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         req;
  logic [7:0]         lock;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         ack;
  logic [2:0]         sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready;

  modport master (
    output req, lock, in_data, out_ready,
    input  ack, sel, out_valid, out_data
  );

  modport slave (
    input  req, lock, in_data, out_ready,
    output ack, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter in front of a shared 8:1 word mux. The selected word
// is captured into a one-entry output register that has valid/ready
// backpressure. A requester may hold its grant for up to MAX_BURST
// consecutive transfers by asserting its lock bit.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mux8_rr_arbiter_if slave modport (req/lock/in_data in,
//           ack/sel out, out_valid/out_data/out_ready output channel)
module mux8_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset,
  mux8_rr_arbiter_if.slave bus
);
  localparam int             CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BURST);

  logic [2:0]       ptr_reg;
  logic [2:0]       last_sel_reg;
  logic [2:0]       owner_reg;
  logic             lock_active_reg;
  logic [CW-1:0]    burst_cnt_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic [WIDTH-1:0] word [8];
  logic [7:0]       req_rot;
  logic [2:0]       rr_off;
  logic [2:0]       rr_winner;
  logic [2:0]       winner;
  logic             any_req;
  logic             hold_lock;
  logic             accept;
  logic             grant;
  logic [CW-1:0]    cnt_next;

  // req_rot[k] is the request of the requester k places after ptr. The
  // lowest set bit of req_rot is therefore the round-robin winner.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign word[gi]    = bus.in_data[gi*WIDTH +: WIDTH];
    assign req_rot[gi] = bus.req[3'(ptr_reg + 3'(gi))];
  end

  always_comb begin
    rr_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) rr_off = 3'(k);
    end
  end

  assign rr_winner = ptr_reg + rr_off;
  assign any_req   = |bus.req;
  // A lock is honoured only while its owner still requests. Otherwise
  // arbitration falls back to round-robin in the same cycle.
  assign hold_lock = lock_active_reg && bus.req[owner_reg];
  assign winner    = hold_lock ? owner_reg : rr_winner;
  assign accept    = !out_valid_reg || bus.out_ready;
  assign grant     = accept && any_req && !reset;

  // When the owner is not requesting, winner never equals owner. Because
  // of that, this condition only ever extends a lock that was honoured.
  assign cnt_next = (lock_active_reg && (winner == owner_reg))
                    ? burst_cnt_reg + CW'(1) : CW'(1);

  assign bus.ack       = grant ? (8'd1 << winner) : 8'd0;
  assign bus.sel       = reset ? 3'd0 : (any_req ? winner : last_sel_reg);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg         <= 3'd0;
      last_sel_reg    <= 3'd0;
      owner_reg       <= 3'd0;
      lock_active_reg <= 1'b0;
      burst_cnt_reg   <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
    end else if (grant) begin
      out_data_reg    <= word[winner];
      out_valid_reg   <= 1'b1;
      last_sel_reg    <= winner;
      ptr_reg         <= winner + 3'd1;
      owner_reg       <= winner;
      burst_cnt_reg   <= cnt_next;
      lock_active_reg <= bus.lock[winner] && (cnt_next < MAX_CNT);
    end else if (accept) begin
      // Nothing requested: the output drains and any lock lapses.
      // out_data keeps its last value.
      out_valid_reg   <= 1'b0;
      lock_active_reg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;

  mux8_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux8_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;   // pulse reset before applying this row
    logic [7:0]  req;
    logic [7:0]  lock;
    logic        rdy;
    logic [7:0]  ack;   // expected before the edge
    logic [2:0]  sel;   // expected before the edge
    logic        valid; // expected after the edge
    logic [31:0] data;  // expected after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [7:0] rq, input logic [7:0] lk, input logic rd,
                     input logic [7:0] a, input logic [2:0] s, input logic v, input logic [31:0] d);
    vec_t t;
    t.rst = r; t.req = rq; t.lock = lk; t.rdy = rd;
    t.ack = a; t.sel = s; t.valid = v; t.data = d;
    vecs.push_back(t);
  endtask

  // Entered and left on a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    bus.req = 8'h00;
    bus.lock = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 8'hFF;
    bus.lock = 8'h08;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) bus.in_data[i*WIDTH +: WIDTH] = 32'h100 + i;

    // Reset state while requests are pending.
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data",  64'(bus.out_data),  64'd0);
    check("rst_ack",   64'(bus.ack),       64'd0);
    check("rst_sel",   64'(bus.sel),       64'd0);
    @(negedge clk);
    @(negedge clk);

    // Full rotation with lock=0.
    for (int i = 0; i < 9; i++)
      add(i == 0, 8'hFF, 8'h00, 1'b1, 8'd1 << (i % 8), 3'(i % 8), 1'b1, 32'h100 + (i % 8));
    // Two requesters alternate. Then nobody requests: the output drains,
    // data holds, and sel shows the last winner.
    add(1, 8'h24, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 32'h102);
    add(0, 8'h24, 8'h00, 1'b1, 8'h20, 3'd5, 1'b1, 32'h105);
    add(0, 8'h24, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 32'h102);
    add(0, 8'h24, 8'h00, 1'b1, 8'h20, 3'd5, 1'b1, 32'h105);
    add(0, 8'h00, 8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 32'h105);
    // Backpressure for 3 cycles, then resume at the next requester.
    add(1, 8'hFF, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 32'h100);
    add(0, 8'hFF, 8'h00, 1'b1, 8'h02, 3'd1, 1'b1, 32'h101);
    for (int i = 0; i < 3; i++)
      add(0, 8'hFF, 8'h00, 1'b0, 8'h00, 3'd2, 1'b1, 32'h101);
    add(0, 8'hFF, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 32'h102);
    // Lock burst by requester 3, capped at 4 transfers.
    add(1, 8'hFF, 8'h08, 1'b1, 8'h01, 3'd0, 1'b1, 32'h100);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h02, 3'd1, 1'b1, 32'h101);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h04, 3'd2, 1'b1, 32'h102);
    for (int i = 0; i < 4; i++)
      add(0, 8'hFF, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 32'h103);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h10, 3'd4, 1'b1, 32'h104);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h20, 3'd5, 1'b1, 32'h105);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h40, 3'd6, 1'b1, 32'h106);
    // Lock released early when the owner drops its request.
    add(1, 8'hFF, 8'h08, 1'b1, 8'h01, 3'd0, 1'b1, 32'h100);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h02, 3'd1, 1'b1, 32'h101);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h04, 3'd2, 1'b1, 32'h102);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 32'h103);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 32'h103);
    add(0, 8'hF7, 8'h08, 1'b1, 8'h10, 3'd4, 1'b1, 32'h104);
    add(0, 8'hFF, 8'h08, 1'b1, 8'h20, 3'd5, 1'b1, 32'h105);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      bus.req = vecs[i].req;
      bus.lock = vecs[i].lock;
      bus.out_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_ack", i), 64'(bus.ack), 64'(vecs[i].ack));
      check($sformatf("v%0d_sel", i), 64'(bus.sel), 64'(vecs[i].sel));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].valid));
      check($sformatf("v%0d_data", i),  64'(bus.out_data),  64'(vecs[i].data));
      $display("vec %0d req=%h lock=%h rdy=%b ack=%h sel=%0d valid=%b data=%h",
               i, vecs[i].req, vecs[i].lock, vecs[i].rdy, vecs[i].ack, vecs[i].sel,
               bus.out_valid, bus.out_data);
      @(negedge clk);
    end

    // Asynchronous reset between edges, in the middle of a locked burst.
    do_reset();
    bus.req = 8'hFF;
    bus.lock = 8'h08;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ar_pre_data", 64'(bus.out_data), 64'h103);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_data",  64'(bus.out_data),  64'd0);
    check("ar_ack",   64'(bus.ack),       64'd0);
    check("ar_sel",   64'(bus.sel),       64'd0);
    $display("async reset mid-burst valid=%b data=%h ack=%h", bus.out_valid, bus.out_data, bus.ack);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 8'h81;
    bus.lock = 8'h00;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] es;
      es = (i == 1) ? 3'd7 : 3'd0;
      #1;
      check($sformatf("ar%0d_ack", i), 64'(bus.ack), 64'(8'd1 << es));
      check($sformatf("ar%0d_sel", i), 64'(bus.sel), 64'(es));
      @(posedge clk);
      #1;
      check($sformatf("ar%0d_data", i), 64'(bus.out_data), 64'(32'h100 + es));
      $display("post-reset grant %0d sel=%0d data=%h", i, es, bus.out_data);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
